mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port of the RV32I core between the instruction-fetch stage and the load/store stage. Each cycle it grants one requester, drives the memory port from the winner and routes read data back after a fixed read latency. Data accesses win by default, and a starvation counter guarantees fetch progress. It sits inside `cpu` between the fetch/LSU stages and the unified instruction/data memory.

## Interface
- `ADDR_W`, 32, address width in bits
- `DATA_W`, 32, data width in bits; the byte-enable width is `DATA_W/8`
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..4
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  load/store request
- `d_we`  in  1  1 = store, 0 = load
- `d_be`  in  DATA_W/8  store byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `mem_en` with `mem_we`=0

## Operation
- **State machine**
  - `IDLE`: no read outstanding.
  - `WAIT`: a read is outstanding. The down-counter `lat_cnt` is loaded with `MEM_LAT` on the grant.
- **Granting**
  - A grant is allowed in `IDLE`, or in `WAIT` when `lat_cnt`=1 (the return cycle).
  - At most one grant per cycle.
- **Priority**
  - `d_req` wins over `if_req`.
  - Exception: when `starve_cnt`=`STARVE_MAX` and `if_req`=1, fetch wins.
- **Starvation counter (`starve_cnt`)**
  - Increments on a data grant while `if_req`=1.
  - Clears on any fetch grant, and in any cycle with `if_req`=0.
  - Saturates at `STARVE_MAX`.
- **Memory port**
  - On a grant, `mem_*` is driven combinationally from the winner. Fetch drives `mem_we`=0 and `mem_be`=all ones.
  - With no grant, `mem_en`=0 and all other `mem_*` outputs are 0.
- **Stores**
  - Complete in the grant cycle. They produce no `rvalid` and do not enter `WAIT`.
- **Loads and fetches**
  - Enter `WAIT`. The owner register records `IF` or `D`.
  - `<owner>_rvalid`=1 in the cycle where `lat_cnt`=1.
  - `if_rdata` and `d_rdata` are both wired to `mem_rdata` and are meaningful only while their `rvalid` is 1.
- **Requester contract**
  - Requesters hold their request and payload stable until `gnt`.
  - A requester may withdraw before `gnt` with no side effect.

## Timing
- `gnt` is combinational from `req`, state and `starve_cnt` in the same cycle.
- Read issued in cycle G: `rvalid` is asserted in cycle G+`MEM_LAT`.
- A new grant is allowed in that same cycle, so reads sustain one per `MEM_LAT` cycles. With `MEM_LAT`=1 this is one per cycle.
- A store may be granted in the return cycle of a read. The `rvalid` of the read is unaffected.
- After `rst`:
  - State is `IDLE`, `lat_cnt`=0, `starve_cnt`=0, owner is `NONE`.
  - All outputs are 0, including `mem_en`, `gnt` and `rvalid`.
- **Reset mid-`WAIT`:** the pending read is dropped. No `rvalid` is asserted for it, at any later cycle.
- **Simultaneous requests at `starve_cnt`<`STARVE_MAX`:** `d_gnt`=1 and `if_gnt`=0.

## Structure
- **Shared package `cpu_mem_pkg`:**
  - `ADDR_W` and `DATA_W` defaults
  - owner enum `{OWN_NONE, OWN_IF, OWN_D}`
  - arbiter state enum `{ARB_IDLE, ARB_WAIT}`
- **Sub-module `mem_arb_prio`:** combinational winner select plus the `starve_cnt` register. The top level holds the FSM, `lat_cnt`, the owner register and the port muxing.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `if_req`=1 -> `mem_en`=0, `if_gnt`=0, `if_rvalid`=0. First grant occurs in the first cycle after `rst`=0.
- **Lone fetch:** `if_req`=1, `if_addr`=0x10, `MEM_LAT`=1, memory returns 0x00190913 -> `if_gnt` in cycle G, `if_rvalid`=1 with `if_rdata`=0x00190913 in G+1.
- **Collision:** `d_req` load at 0x100 and `if_req` at 0x20 in the same cycle -> `d_gnt` first, then `if_gnt` in the `rvalid` cycle of the load. `d_rvalid` and `if_rvalid` each pulse exactly once.
- **Starvation:** `d_req` held with back-to-back loads and `if_req` held, `STARVE_MAX`=4 -> grant order is D,D,D,D,IF,D.
- **Store inside read return:** fetch read in flight with `MEM_LAT`=2, store `d_be`=0b0011 at 0x200 requested in the return cycle -> `mem_we`=1, `mem_be`=0b0011 in that cycle. `if_rvalid`=1 in the same cycle. No `d_rvalid`.
- **Reset during `WAIT`:** `MEM_LAT`=3, assert `rst` one cycle after a load grant -> no `d_rvalid` within the next 5 cycles. State is `IDLE`.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory subsystem: default bus widths,
// the read-owner tag and the arbiter state encoding.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the
// arbiter. The master side is the surrounding pipeline plus memory;
// the slave side is the arbiter itself.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  // Shared memory port
  logic                mem_en;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and load/store. Data normally wins;
// the starvation counter forces one fetch grant after STARVE_MAX
// consecutive data grants taken while fetch was waiting.
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifReq_i,
  input  logic dReq_i,
  input  logic grantOk_i,
  output logic ifGnt_o,
  output logic dGnt_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starveCnt_q;
  logic [3:0] starveCnt_d;
  logic       fetchFirst;

  // Pick the winner for this cycle; fetch overrides data only once starved
  always_comb begin
    fetchFirst = ifReq_i && (starveCnt_q == STARVE_LIM);
    ifGnt_o    = grantOk_i && ifReq_i && (fetchFirst || !dReq_i);
    dGnt_o     = grantOk_i && dReq_i && !fetchFirst;
  end

  // Count data grants that bypassed a waiting fetch, saturating at the limit
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!ifReq_i || ifGnt_o) begin
      starveCnt_d = 4'd0;
    end else if (dGnt_o && (starveCnt_q != STARVE_LIM)) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt_q <= 4'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch and
// the load/store unit. One grant per cycle, reads return MEM_LAT cycles
// later and are steered back to whichever requester issued them.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  arb_state_e state_q;
  arb_state_e state_d;
  logic [2:0] latCnt_q;
  logic [2:0] latCnt_d;
  owner_e     owner_q;
  owner_e     owner_d;

  logic returnCycle;
  logic grantOk;
  logic ifGnt;
  logic dGnt;

  logic              muxEn;
  logic              muxWe;
  logic [BE_W-1:0]   muxBe;
  logic [ADDR_W-1:0] muxAddr;
  logic [DATA_W-1:0] muxWdata;

  // Reset masks every grant and return so nothing leaks out while rst is high
  assign returnCycle = !rst && (state_q == ARB_WAIT) && (latCnt_q == 3'd1);
  assign grantOk     = !rst && ((state_q == ARB_IDLE) || returnCycle);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst       (rst),
    .ifReq_i   (bus.if_req),
    .dReq_i    (bus.d_req),
    .grantOk_i (grantOk),
    .ifGnt_o   (ifGnt),
    .dGnt_o    (dGnt)
  );

  assign bus.if_gnt   = ifGnt;
  assign bus.d_gnt    = dGnt;
  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

  // FSM next state, latency countdown, read owner and return strobes
  always_comb begin
    state_d       = state_q;
    latCnt_d      = latCnt_q;
    owner_d       = owner_q;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;

    if (state_q == ARB_WAIT) begin
      if (latCnt_q == 3'd1) begin
        state_d  = ARB_IDLE;
        latCnt_d = 3'd0;
        owner_d  = OWN_NONE;
      end else begin
        latCnt_d = latCnt_q - 3'd1;
      end
    end

    if (returnCycle) begin
      bus.if_rvalid = (owner_q == OWN_IF);
      bus.d_rvalid  = (owner_q == OWN_D);
    end

    // A read granted in the return cycle takes over the freshly freed slot
    if (ifGnt) begin
      state_d  = ARB_WAIT;
      latCnt_d = LAT_LOAD;
      owner_d  = OWN_IF;
    end else if (dGnt && !bus.d_we) begin
      state_d  = ARB_WAIT;
      latCnt_d = LAT_LOAD;
      owner_d  = OWN_D;
    end
  end

  // Arbiter state registers; reset drops any read still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      latCnt_q <= 3'd0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      latCnt_q <= latCnt_d;
      owner_q  <= owner_d;
    end
  end

  // Drive the memory port from the winner, or hold it fully quiet
  always_comb begin
    muxEn    = 1'b0;
    muxWe    = 1'b0;
    muxBe    = '0;
    muxAddr  = '0;
    muxWdata = '0;
    if (ifGnt) begin
      muxEn   = 1'b1;
      muxBe   = '1;
      muxAddr = bus.if_addr;
    end else if (dGnt) begin
      muxEn    = 1'b1;
      muxWe    = bus.d_we;
      muxBe    = bus.d_be;
      muxAddr  = bus.d_addr;
      muxWdata = bus.d_wdata;
    end
  end

  assign bus.mem_en    = muxEn;
  assign bus.mem_we    = muxWe;
  assign bus.mem_be    = muxBe;
  assign bus.mem_addr  = muxAddr;
  assign bus.mem_wdata = muxWdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three copies run side by side with
// MEM_LAT = 1, 2 and 3 on identical stimulus; each scenario checks the
// copy whose latency it is written for. Inputs change just after the
// rising edge, outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        dReq;
  logic        dWe;
  logic [3:0]  dBe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [31:0] memRdata;

  logic        ifGntV    [3];
  logic        dGntV     [3];
  logic        ifRvV     [3];
  logic        dRvV      [3];
  logic        memEnV    [3];
  logic        memWeV    [3];
  logic [3:0]  memBeV    [3];
  logic [31:0] memAddrV  [3];
  logic [31:0] memWdataV [3];
  logic [31:0] ifRdataV  [3];
  logic [31:0] dRdataV   [3];

  int checkCount = 0;
  int passCount  = 0;

  // One DUT per read latency, all fed from the same stimulus variables
  for (genvar g = 0; g < 3; g++) begin : gLat
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.if_req    = ifReq;
    assign bus.if_addr   = ifAddr;
    assign bus.d_req     = dReq;
    assign bus.d_we      = dWe;
    assign bus.d_be      = dBe;
    assign bus.d_addr    = dAddr;
    assign bus.d_wdata   = dWdata;
    assign bus.mem_rdata = memRdata;

    assign ifGntV[g]    = bus.if_gnt;
    assign dGntV[g]     = bus.d_gnt;
    assign ifRvV[g]     = bus.if_rvalid;
    assign dRvV[g]      = bus.d_rvalid;
    assign memEnV[g]    = bus.mem_en;
    assign memWeV[g]    = bus.mem_we;
    assign memBeV[g]    = bus.mem_be;
    assign memAddrV[g]  = bus.mem_addr;
    assign memWdataV[g] = bus.mem_wdata;
    assign ifRdataV[g]  = bus.if_rdata;
    assign dRdataV[g]   = bus.d_rdata;

    mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .MEM_LAT    (g + 1),
      .STARVE_MAX (4)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dr, input logic we, input logic [3:0] be,
                               input logic [31:0] da, input logic [31:0] dw);
    ifReq  = iReq;
    ifAddr = iAddr;
    dReq   = dr;
    dWe    = we;
    dBe    = be;
    dAddr  = da;
    dWdata = dw;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleWindow();
    @(negedge clk);
  endtask

  task automatic resetDut(input int cycles);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (cycles) nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    int ifRvSeen;
    int dRvSeen;
    logic expD [6];

    rst      = 1'b1;
    memRdata = 32'h0019_0913;

    // Reset held with a pending fetch: nothing may be granted or returned
    $display("[TB] reset behaviour and lone fetch");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sampleWindow();
      checkOutput("rst_mem_en", 32'(memEnV[0]), 32'd0);
      checkOutput("rst_if_gnt", 32'(ifGntV[0]), 32'd0);
      checkOutput("rst_if_rvalid", 32'(ifRvV[0]), 32'd0);
      nextCycle();
    end
    rst = 1'b0;
    sampleWindow();
    checkOutput("fetch_if_gnt", 32'(ifGntV[0]), 32'd1);
    checkOutput("fetch_d_gnt", 32'(dGntV[0]), 32'd0);
    checkOutput("fetch_mem_en", 32'(memEnV[0]), 32'd1);
    checkOutput("fetch_mem_we", 32'(memWeV[0]), 32'd0);
    checkOutput("fetch_mem_be", 32'(memBeV[0]), 32'hF);
    checkOutput("fetch_mem_addr", memAddrV[0], 32'h10);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sampleWindow();
    checkOutput("fetch_if_rvalid", 32'(ifRvV[0]), 32'd1);
    checkOutput("fetch_if_rdata", ifRdataV[0], 32'h0019_0913);
    checkOutput("fetch_d_rvalid", 32'(dRvV[0]), 32'd0);
    checkOutput("fetch_idle_mem_en", 32'(memEnV[0]), 32'd0);
    checkOutput("fetch_lat2_early", 32'(ifRvV[1]), 32'd0);
    nextCycle();
    sampleWindow();
    checkOutput("fetch_lat2_rvalid", 32'(ifRvV[1]), 32'd1);
    checkOutput("fetch_rvalid_once", 32'(ifRvV[0]), 32'd0);

    // Load and fetch collide: load first, fetch takes the load's return slot
    $display("[TB] collision");
    resetDut(2);
    memRdata = 32'h1234_5678;
    ifRvSeen = 0;
    dRvSeen  = 0;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    sampleWindow();
    checkOutput("coll_d_gnt", 32'(dGntV[0]), 32'd1);
    checkOutput("coll_if_gnt", 32'(ifGntV[0]), 32'd0);
    checkOutput("coll_mem_addr_d", memAddrV[0], 32'h100);
    ifRvSeen += int'(ifRvV[0]);
    dRvSeen  += int'(dRvV[0]);
    nextCycle();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sampleWindow();
    checkOutput("coll_d_rvalid", 32'(dRvV[0]), 32'd1);
    checkOutput("coll_d_rdata", dRdataV[0], 32'h1234_5678);
    checkOutput("coll_if_gnt_ret", 32'(ifGntV[0]), 32'd1);
    checkOutput("coll_mem_addr_if", memAddrV[0], 32'h20);
    ifRvSeen += int'(ifRvV[0]);
    dRvSeen  += int'(dRvV[0]);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sampleWindow();
    checkOutput("coll_if_rvalid", 32'(ifRvV[0]), 32'd1);
    ifRvSeen += int'(ifRvV[0]);
    dRvSeen  += int'(dRvV[0]);
    nextCycle();
    sampleWindow();
    ifRvSeen += int'(ifRvV[0]);
    dRvSeen  += int'(dRvV[0]);
    checkOutput("coll_d_rvalid_pulses", 32'(dRvSeen), 32'd1);
    checkOutput("coll_if_rvalid_pulses", 32'(ifRvSeen), 32'd1);

    // Back-to-back loads against a waiting fetch: D,D,D,D,IF,D
    $display("[TB] starvation");
    resetDut(2);
    expD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h180, 32'h0);
    for (int i = 0; i < 6; i++) begin
      sampleWindow();
      checkOutput($sformatf("starve_d_gnt_%0d", i), 32'(dGntV[0]), 32'(expD[i]));
      checkOutput($sformatf("starve_if_gnt_%0d", i), 32'(ifGntV[0]), 32'(!expD[i]));
      nextCycle();
    end

    // Store granted in the return cycle of a latency-2 fetch
    $display("[TB] store inside read return");
    resetDut(2);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sampleWindow();
    checkOutput("st_if_gnt", 32'(ifGntV[1]), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sampleWindow();
    checkOutput("st_if_rvalid_early", 32'(ifRvV[1]), 32'd0);
    checkOutput("st_mem_en_quiet", 32'(memEnV[1]), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D);
    sampleWindow();
    checkOutput("st_d_gnt", 32'(dGntV[1]), 32'd1);
    checkOutput("st_mem_en", 32'(memEnV[1]), 32'd1);
    checkOutput("st_mem_we", 32'(memWeV[1]), 32'd1);
    checkOutput("st_mem_be", 32'(memBeV[1]), 32'h3);
    checkOutput("st_mem_addr", memAddrV[1], 32'h200);
    checkOutput("st_mem_wdata", memWdataV[1], 32'hCAFE_F00D);
    checkOutput("st_if_rvalid", 32'(ifRvV[1]), 32'd1);
    checkOutput("st_d_rvalid", 32'(dRvV[1]), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sampleWindow();
      checkOutput($sformatf("st_no_d_rvalid_%0d", i), 32'(dRvV[1]), 32'd0);
      checkOutput($sformatf("st_no_if_rvalid_%0d", i), 32'(ifRvV[1]), 32'd0);
      nextCycle();
    end

    // Reset one cycle after a latency-3 load grant drops the read
    $display("[TB] reset during wait");
    resetDut(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    sampleWindow();
    checkOutput("wrst_d_gnt", 32'(dGntV[2]), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    sampleWindow();
    checkOutput("wrst_d_rvalid_in_rst", 32'(dRvV[2]), 32'd0);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sampleWindow();
      if (i == 0) begin
        checkOutput("wrst_state_idle", 32'(gLat[2].dut.state_q), 32'(ARB_IDLE));
      end
      checkOutput($sformatf("wrst_no_d_rvalid_%0d", i), 32'(dRvV[2]), 32'd0);
      nextCycle();
    end

    // After the dropped read the latency-3 copy accepts and returns normally
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0);
    sampleWindow();
    checkOutput("lat3_d_gnt", 32'(dGntV[2]), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      sampleWindow();
      checkOutput($sformatf("lat3_d_rvalid_g%0d", i), 32'(dRvV[2]), 32'(i == 3));
      nextCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
